// File: rtl/dw_gearbox.sv
// Width-converting gearbox: packs DW_IN-bit input words into DW_OUT-bit output words,
// LSB first, with packet framing via last and a partial final word flagged by bits_o.
module dw_gearbox #(
  parameter int DW_IN  = 16,
  parameter int DW_OUT = 12
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DW_IN-1:0]              din_i,
  input  logic                          last_i,
  input  logic                          vld_i,
  output logic                          rdy_o,
  output logic [DW_OUT-1:0]             dout_o,
  output logic [$clog2(DW_OUT+1)-1:0]   bits_o,
  output logic                          last_o,
  output logic                          vld_o,
  input  logic                          rdy_i
);

  localparam int BUF_W  = DW_IN + DW_OUT;
  localparam int CNT_W  = $clog2(BUF_W + 1);
  localparam int BITS_W = $clog2(DW_OUT + 1);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(DW_OUT);
  localparam logic [CNT_W-1:0] IN_C  = CNT_W'(DW_IN);

  if (DW_IN < 1 || DW_OUT < 1) begin : g_bad_param
    $fatal(1, "dw_gearbox: DW_IN and DW_OUT must both be >= 1");
  end

  logic [BUF_W-1:0] buf_q, buf_d, shifted, ins;
  logic [CNT_W-1:0] cnt_q, cnt_d, take, pop_amt, cnt_mid;
  logic             flush_q, flush_d;
  logic             full_word, push, pop;

  // All handshake outputs derive from registered state only.
  assign full_word = (cnt_q >= OUT_C);
  assign rdy_o     = ~flush_q & (cnt_q <= OUT_C);
  assign vld_o     = full_word | (flush_q & (cnt_q != '0));
  assign last_o    = flush_q & (cnt_q <= OUT_C) & (cnt_q != '0);
  assign take      = full_word ? OUT_C : cnt_q;
  assign bits_o    = BITS_W'(take);

  always_comb begin
    dout_o = '0;
    for (int i = 0; i < DW_OUT; i++) begin
      dout_o[i] = buf_q[i] & (CNT_W'(i) < cnt_q);
    end
  end

  assign push = vld_i & rdy_o;
  assign pop  = vld_o & rdy_i;

  // A same-cycle push lands just above whatever survives the pop.
  assign pop_amt = pop ? take : '0;
  assign shifted = buf_q >> pop_amt;
  assign cnt_mid = cnt_q - pop_amt;
  assign ins     = BUF_W'(din_i) << cnt_mid;

  always_comb begin
    buf_d   = shifted;
    cnt_d   = cnt_mid;
    flush_d = flush_q;
    if (push) begin
      buf_d = shifted | ins;
      cnt_d = cnt_mid + IN_C;
    end
    if (push && last_i) begin
      flush_d = 1'b1;
    end else if (pop && last_o) begin
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

endmodule

// File: tb/tb_dw_gearbox.sv
// Scoreboard bench for dw_gearbox: five width pairs run side by side, each checked against
// a bit-queue reference model of the packet stream.
`timescale 1ns/1ps
module tb_dw_gearbox;

  localparam int NCFG  = 5;
  localparam int NPKT  = 5000;
  localparam int BOUND = 400;
  localparam int DI_T [NCFG] = '{16, 16, 8, 12, 8};
  localparam int DO_T [NCFG] = '{8, 12, 16, 16, 8};

  localparam int DIR_N [NCFG] = '{1, 2, 3, 0, 0};
  localparam logic [31:0] DIR_W [NCFG][3] = '{
    '{32'hBEEF, 32'h0,    32'h0},
    '{32'h0123, 32'h4567, 32'h0},
    '{32'h11,   32'h22,   32'h33},
    '{32'h0,    32'h0,    32'h0},
    '{32'h0,    32'h0,    32'h0}};
  localparam int EXP_STALL [NCFG] = '{0, 1, 0, 0, 0};

  localparam int EXP_N [NCFG] = '{2, 3, 2, 0, 0};
  localparam logic [31:0] EXP_D [NCFG][3] = '{
    '{32'hEF,   32'hBE,   32'h0},
    '{32'h123,  32'h670,  32'h45},
    '{32'h2211, 32'h0033, 32'h0},
    '{32'h0,    32'h0,    32'h0},
    '{32'h0,    32'h0,    32'h0}};
  localparam int EXP_B   [NCFG][3] = '{'{8, 8, 0}, '{12, 12, 8}, '{16, 8, 0}, '{0, 0, 0}, '{0, 0, 0}};
  localparam int EXP_L   [NCFG][3] = '{'{0, 1, 0}, '{0, 0, 1}, '{0, 1, 0}, '{0, 0, 0}, '{0, 0, 0}};
  localparam int EXP_GAP [NCFG][3] = '{'{0, 1, 0}, '{0, 2, 1}, '{0, 1, 0}, '{0, 0, 0}, '{0, 0, 0}};

  typedef struct {
    logic [31:0] d;
    int          b;
    bit          l;
  } exp_t;

  int   compared   = 0;
  int   mismatched = 0;
  int   done_cnt   = 0;
  logic clk        = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input int cfg, input string nm, input longint act, input longint exp);
    compared++;
    if (!ok) begin
      mismatched++;
      $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, nm, act, exp);
    end
  endtask

  task automatic mark_done();
    done_cnt++;
  endtask

  for (genvar G = 0; G < NCFG; G++) begin : g_cfg
    localparam int DI = DI_T[G];
    localparam int DO = DO_T[G];
    localparam int BO = $clog2(DO + 1);

    logic          rst;
    logic [DI-1:0] din;
    logic          last_in, vld_in, rdy_out;
    logic [DO-1:0] dout;
    logic [BO-1:0] bits;
    logic          last_out, vld_out, rdy_in;

    bit     bitq[$];
    exp_t   exp_q[$];
    longint pushed, popped;
    bit     flush_m;
    int     mmode;
    int     stall;

    dw_gearbox #(.DW_IN(DI), .DW_OUT(DO)) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .din_i (din),
      .last_i(last_in),
      .vld_i (vld_in),
      .rdy_o (rdy_out),
      .dout_o(dout),
      .bits_o(bits),
      .last_o(last_out),
      .vld_o (vld_out),
      .rdy_i (rdy_in)
    );

    task automatic emit(input int n, input bit l);
      exp_t e;
      e.d = '0;
      e.b = n;
      e.l = l;
      for (int i = 0; i < n; i++) e.d[i] = bitq.pop_front();
      exp_q.push_back(e);
    endtask

    // Full words leave as soon as they exist; the tail of a packet always carries last.
    task automatic model_push(input logic [31:0] w, input bit l);
      for (int i = 0; i < DI; i++) bitq.push_back(w[i]);
      pushed += DI;
      if (l) begin
        flush_m = 1'b1;
        while (bitq.size() > DO) emit(DO, 1'b0);
        emit(bitq.size(), 1'b1);
      end else begin
        while (bitq.size() >= DO) emit(DO, 1'b0);
      end
    endtask

    task automatic send(input logic [31:0] w, input bit l, input int idle_pct);
      int waitc;
      bit sent;
      waitc = 0;
      sent  = 1'b0;
      while (idle_pct > 0 && int'($urandom_range(99)) < idle_pct) begin
        vld_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
      din     = w[DI-1:0];
      last_in = l;
      vld_in  = 1'b1;
      while (!sent && waitc < BOUND) begin
        if (rdy_out) begin
          sent = 1'b1;
          @(posedge clk);
          model_push(w, l);
        end else begin
          stall++;
          waitc++;
          @(posedge clk);
        end
        @(negedge clk);
      end
      vld_in  = 1'b0;
      last_in = 1'b0;
      chk(sent, G, "push_accepted", waitc, BOUND);
    endtask

    task automatic fill();
      int n;
      n = 0;
      while (rdy_out && n < 16) begin
        send($urandom, 1'b0, 0);
        n++;
      end
      chk(rdy_out == 1'b0, G, "rdy_low_when_full", rdy_out, 0);
    endtask

    task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk(exp_q.size() == 0, G, "drain", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs();
      chk(rdy_out == 1'b1,  G, "reset_rdy_o",  rdy_out,  1);
      chk(vld_out == 1'b0,  G, "reset_vld_o",  vld_out,  0);
      chk(last_out == 1'b0, G, "reset_last_o", last_out, 0);
      chk(bits == '0,       G, "reset_bits_o", bits,     0);
      chk(dout == '0,       G, "reset_dout_o", dout,     0);
    endtask

    initial begin
      int nw;
      rst = 1'b1; din = '0; last_in = 1'b0; vld_in = 1'b0;
      mmode = 0; stall = 0; pushed = 0; popped = 0; flush_m = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs();

      for (int k = 0; k < DIR_N[G]; k++) send(DIR_W[G][k], k == DIR_N[G] - 1, 0);
      chk(stall == EXP_STALL[G], G, "directed_stalls", stall, EXP_STALL[G]);
      drain();

      // Backpressure: fill with the sink stalled, hold it, then finish the packet.
      mmode = 1;
      @(negedge clk);
      fill();
      chk(vld_out == 1'b1, G, "vld_when_full", vld_out, 1);
      repeat (5) @(negedge clk);
      mmode = 0;
      send($urandom, 1'b1, 0);
      drain();

      // Reset in the middle of a buffered packet.
      mmode = 1;
      @(negedge clk);
      fill();
      rst = 1'b1;
      @(posedge clk);
      bitq.delete();
      exp_q.delete();
      pushed  = 0;
      popped  = 0;
      flush_m = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_outputs();
      mmode = 0;
      send(32'hA5A5, 1'b1, 0);
      drain();

      mmode = 2;
      for (int p = 0; p < NPKT; p++) begin
        nw = int'($urandom_range(3, 1));
        for (int k = 0; k < nw; k++) send($urandom, k == nw - 1, 15);
      end
      mmode = 0;
      drain();
      mark_done();
    end

    initial begin
      logic [DO-1:0] hd;
      logic [BO-1:0] hb;
      logic          hl;
      bit            held;
      int            cyc, last_pop, oidx;
      longint        infl;
      exp_t          e;
      held = 1'b0; cyc = 0; last_pop = 0; oidx = 0;
      hd = '0; hb = '0; hl = 1'b0;
      rdy_in = 1'b1;
      forever begin
        @(negedge clk);
        cyc++;
        if (mmode == 2) rdy_in = (int'($urandom_range(99)) < 75);
        else            rdy_in = (mmode == 0);

        infl = pushed - popped;
        chk(vld_out == ((infl >= DO) || (flush_m && infl > 0)), G, "vld_o", vld_out, infl);
        chk(rdy_out == (!flush_m && infl <= DO), G, "rdy_o", rdy_out, infl);
        if (!vld_out) chk(last_out == 1'b0, G, "last_without_vld", last_out, 0);
        if (held && vld_out) begin
          chk(dout == hd,     G, "stall_dout", dout, hd);
          chk(bits == hb,     G, "stall_bits", bits, hb);
          chk(last_out == hl, G, "stall_last", last_out, hl);
        end
        held = vld_out && !rdy_in;
        hd = dout;
        hb = bits;
        hl = last_out;

        if (vld_out && rdy_in) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, G, "unexpected_output", dout, 0);
          end else begin
            e = exp_q.pop_front();
            chk(32'(dout) == e.d, G, "dout", dout, e.d);
            chk(int'(bits) == e.b, G, "bits", bits, e.b);
            chk(last_out == e.l, G, "last", last_out, e.l);
            if (oidx < EXP_N[G]) begin
              chk(32'(dout) == EXP_D[G][oidx], G, "directed_dout", dout, EXP_D[G][oidx]);
              chk(int'(bits) == EXP_B[G][oidx], G, "directed_bits", bits, EXP_B[G][oidx]);
              chk(int'(last_out) == EXP_L[G][oidx], G, "directed_last", last_out, EXP_L[G][oidx]);
              if (oidx > 0)
                chk(cyc - last_pop == EXP_GAP[G][oidx], G, "directed_gap", cyc - last_pop, EXP_GAP[G][oidx]);
            end
            oidx++;
            last_pop = cyc;
            @(posedge clk);
            popped += e.b;
            if (e.l) flush_m = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    fork
      wait (done_cnt == NCFG);
      #(90000 * 10);
    join_any
    chk(done_cnt == NCFG, -1, "run_timeout", done_cnt, NCFG);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
